// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and operand-class helpers for the RV32M multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_OP_MUL    = 3'd0,
    MD_OP_MULH   = 3'd1,
    MD_OP_MULHSU = 3'd2,
    MD_OP_MULHU  = 3'd3,
    MD_OP_DIV    = 3'd4,
    MD_OP_DIVU   = 3'd5,
    MD_OP_REM    = 3'd6,
    MD_OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_ST_IDLE,
    MD_ST_MUL,
    MD_ST_DIV,
    MD_ST_DONE
  } md_state_e;

  function automatic logic mul_rs1_signed(input md_op_e op);
    return (op == MD_OP_MUL) || (op == MD_OP_MULH) || (op == MD_OP_MULHSU);
  endfunction

  function automatic logic mul_rs2_signed(input md_op_e op);
    return (op == MD_OP_MUL) || (op == MD_OP_MULH);
  endfunction

  function automatic logic div_signed(input md_op_e op);
    return (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

  function automatic logic div_is_rem(input md_op_e op);
    return (op == MD_OP_REM) || (op == MD_OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative unsigned restoring divider: one quotient bit per edge, MSB first.
module muldiv_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]   cnt;
  logic            running;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // quotient doubles as the dividend shift register; its MSB feeds the partial remainder
  assign shifted = {remainder, quotient[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      divisor_q <= '0;
      cnt       <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else if (kill) begin
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      quotient  <= dividend;
      remainder <= '0;
      divisor_q <= divisor;
      cnt       <= '0;
      running   <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (running) begin
        if (!diff[XLEN]) begin
          remainder <= diff[XLEN-1:0];
          quotient  <= {quotient[XLEN-2:0], 1'b1};
        end else begin
          remainder <= shifted[XLEN-1:0];
          quotient  <= {quotient[XLEN-2:0], 1'b0};
        end
        cnt <= cnt + 1'b1;
        if (cnt == CW'(XLEN - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: pipelined multiplier, iterative divider with
// single-cycle divide-by-zero and signed-overflow fast paths.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  md_state_e state_q, state_d;
  md_op_e    op;
  logic      accept;

  assign op     = md_op_e'(op_i);
  assign accept = start_i && !kill_i && (state_q == MD_ST_IDLE || state_q == MD_ST_DONE);

  // Multiply: sign-extend to 2*XLEN so the low 2*XLEN product bits are exact for every mix
  logic                   ext1, ext2;
  logic signed [2*XLEN-1:0] mul_a, mul_b, product;
  logic [XLEN-1:0]        mul_sel;
  logic [XLEN-1:0]        mul_pipe [MUL_LATENCY];
  logic [2:0]             mul_cnt;
  logic                   mul_last;

  assign ext1     = mul_rs1_signed(op) & rs1_val_i[XLEN-1];
  assign ext2     = mul_rs2_signed(op) & rs2_val_i[XLEN-1];
  assign mul_a    = {{XLEN{ext1}}, rs1_val_i};
  assign mul_b    = {{XLEN{ext2}}, rs2_val_i};
  assign product  = mul_a * mul_b;
  assign mul_sel  = (op == MD_OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  assign mul_last = (mul_cnt == 3'(MUL_LATENCY - 1));

  logic            sdiv, rs1_neg, rs2_neg, div_by_zero, div_ovf, div_start;
  logic [XLEN-1:0] dividend_mag, divisor_mag, fast_res;
  logic [XLEN-1:0] div_quo, div_rem, div_fixed;
  logic            div_done;
  logic            fast_q, is_rem_q, neg_quo_q, neg_rem_q;
  logic [XLEN-1:0] fast_res_q;

  assign sdiv         = div_signed(op);
  assign rs1_neg      = sdiv & rs1_val_i[XLEN-1];
  assign rs2_neg      = sdiv & rs2_val_i[XLEN-1];
  assign div_by_zero  = (rs2_val_i == '0);
  assign div_ovf      = sdiv && (rs1_val_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val_i == '1);
  assign dividend_mag = rs1_neg ? -rs1_val_i : rs1_val_i;
  assign divisor_mag  = rs2_neg ? -rs2_val_i : rs2_val_i;
  assign div_start    = accept && op_i[2] && !div_by_zero && !div_ovf;

  always_comb begin
    fast_res = '1;
    if (div_by_zero)
      fast_res = div_is_rem(op) ? rs1_val_i : '1;
    else if (div_ovf)
      fast_res = div_is_rem(op) ? '0 : rs1_val_i;
  end

  // Remainder follows the dividend's sign, quotient the xor of both signs
  assign div_fixed = is_rem_q ? (neg_rem_q ? -div_rem : div_rem)
                              : (neg_quo_q ? -div_quo : div_quo);

  muldiv_divider #(.XLEN(XLEN)) u_divider (
    .clk       (clk_i),
    .rst       (rst_i),
    .start     (div_start),
    .kill      (kill_i),
    .dividend  (dividend_mag),
    .divisor   (divisor_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= MD_ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_o  = (state_q == MD_ST_MUL) || (state_q == MD_ST_DIV);
    valid_o = (state_q == MD_ST_DONE);
    if (kill_i) begin
      state_d = MD_ST_IDLE;
    end else begin
      case (state_q)
        MD_ST_IDLE, MD_ST_DONE:
          state_d = start_i ? (op_i[2] ? MD_ST_DIV : MD_ST_MUL) : MD_ST_IDLE;
        MD_ST_MUL: if (mul_last) state_d = MD_ST_DONE;
        MD_ST_DIV: if (fast_q || div_done) state_d = MD_ST_DONE;
        default:   state_d = MD_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MUL_LATENCY; i++) mul_pipe[i] <= '0;
      mul_cnt    <= '0;
      fast_q     <= 1'b0;
      fast_res_q <= '0;
      is_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_o   <= '0;
    end else begin
      for (int i = 1; i < MUL_LATENCY; i++) mul_pipe[i] <= mul_pipe[i-1];
      if (accept) begin
        mul_pipe[0] <= mul_sel;
        mul_cnt     <= '0;
        fast_q      <= div_by_zero || div_ovf;
        fast_res_q  <= fast_res;
        is_rem_q    <= div_is_rem(op);
        neg_quo_q   <= rs1_neg ^ rs2_neg;
        neg_rem_q   <= rs1_neg;
      end else if (state_q == MD_ST_MUL) begin
        mul_cnt <= mul_cnt + 3'd1;
      end
      if (!kill_i) begin
        if (state_q == MD_ST_MUL && mul_last)
          result_o <= mul_pipe[MUL_LATENCY-1];
        else if (state_q == MD_ST_DIV && fast_q)
          result_o <= fast_res_q;
        else if (state_q == MD_ST_DIV && div_done)
          result_o <= div_fixed;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit (XLEN=32, MUL_LATENCY=2).
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, kill_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_val_i, rs2_val_i;
  logic        busy_o, valid_o;
  logic [31:0] result_o;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  muldiv_unit #(.XLEN(32), .MUL_LATENCY(2)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .kill_i    (kill_i),
    .op_i      (op_i),
    .rs1_val_i (rs1_val_i),
    .rs2_val_i (rs2_val_i),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .result_o  (result_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk_i) begin
    if (rst_i === 1'b0 && valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_valid: got valid_o=1 at cycle %0d, expected none", cycle);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput({e.name, " result"}, result_o, e.res);
        checkOutput({e.name, " latency"}, cycle, e.cyc);
        checkOutput({e.name, " busy_at_valid"}, {31'd0, busy_o}, 32'd0);
      end
    end
  end

  task automatic applyStimulus(input md_op_e op, input logic [31:0] a, input logic [31:0] b, output int c0);
    start_i   = 1'b1;
    op_i      = op;
    rs1_val_i = a;
    rs2_val_i = b;
    @(posedge clk_i); #1;
    c0      = cycle;
    start_i = 1'b0;
    checkOutput("busy_after_accept", {31'd0, busy_o}, 32'd1);
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(posedge clk_i); #1;
      n++;
      checkOutput({name, " busy_vs_valid"}, {31'd0, busy_o}, {31'd0, !valid_o});
      seen = valid_o;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL %s timeout: got no valid_o in %0d cycles, expected one", name, budget);
      sb.delete();
    end
    @(negedge clk_i); #1;
  endtask

  task automatic runOp(input string name, input md_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat);
    int c0;
    applyStimulus(op, a, b, c0);
    sb.push_back('{res: res, cyc: c0 + lat, name: name});
    waitDrain(name, lat + 5);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0, c1;
    rst_i = 1'b1; start_i = 1'b0; kill_i = 1'b0;
    op_i = 3'd0; rs1_val_i = '0; rs2_val_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset busy", {31'd0, busy_o}, 32'd0);
    checkOutput("reset valid", {31'd0, valid_o}, 32'd0);
    checkOutput("reset result", result_o, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    runOp("MUL -1*-1",    MD_OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 2);
    runOp("MULH -1*-1",   MD_OP_MULH,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2);
    runOp("MULHU max^2",  MD_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
    runOp("DIV -7/2",     MD_OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
    runOp("REM -7/2",     MD_OP_REM,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
    runOp("REM 7/-2",     MD_OP_REM,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33);
    runOp("DIVU 100/0",   MD_OP_DIVU,  32'h00000064, 32'h00000000, 32'hFFFFFFFF, 1);
    runOp("REMU 100/0",   MD_OP_REMU,  32'h00000064, 32'h00000000, 32'h00000064, 1);
    runOp("DIV -5/0",     MD_OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 1);
    runOp("DIV ovf",      MD_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    runOp("REM ovf",      MD_OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // start held high while busy, operands changed after accept: exactly one result
    start_i = 1'b1; op_i = MD_OP_DIV; rs1_val_i = 32'hFFFFFFF9; rs2_val_i = 32'h00000002;
    @(posedge clk_i); #1;
    c0 = cycle;
    sb.push_back('{res: 32'hFFFFFFFD, cyc: c0 + 33, name: "DIV held start"});
    rs1_val_i = 32'd100; rs2_val_i = 32'd3;
    repeat (4) @(posedge clk_i);
    #1;
    checkOutput("held start busy", {31'd0, busy_o}, 32'd1);
    start_i = 1'b0;
    waitDrain("DIV held start", 40);
    repeat (10) @(posedge clk_i);
    #1;

    // kill at iteration 10
    applyStimulus(MD_OP_DIVU, 32'd1000, 32'd7, c0);
    repeat (9) @(posedge clk_i);
    #1 kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    checkOutput("kill busy", {31'd0, busy_o}, 32'd0);
    checkOutput("kill valid", {31'd0, valid_o}, 32'd0);
    checkOutput("kill result held", result_o, 32'hFFFFFFFD);
    repeat (40) @(posedge clk_i);
    #1;
    checkOutput("after kill busy", {31'd0, busy_o}, 32'd0);

    // kill beats start in the same cycle
    start_i = 1'b1; kill_i = 1'b1; op_i = MD_OP_MUL;
    @(posedge clk_i); #1;
    start_i = 1'b0; kill_i = 1'b0;
    checkOutput("kill over start busy", {31'd0, busy_o}, 32'd0);
    repeat (4) @(posedge clk_i);
    #1;

    // MULHSU then back-to-back DIVU accepted in the DONE cycle
    applyStimulus(MD_OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, c0);
    sb.push_back('{res: 32'hFFFFFFFF, cyc: c0 + 2, name: "MULHSU -1*2"});
    @(posedge clk_i); #1;
    checkOutput("MULHSU busy edge1", {31'd0, busy_o}, 32'd1);
    @(posedge clk_i); #1;
    checkOutput("MULHSU valid edge2", {31'd0, valid_o}, 32'd1);
    applyStimulus(MD_OP_DIVU, 32'd1000, 32'd7, c1);
    sb.push_back('{res: 32'h0000008E, cyc: c1 + 33, name: "DIVU b2b"});
    waitDrain("DIVU b2b", 40);

    // asynchronous reset in the middle of a divide
    applyStimulus(MD_OP_DIV, 32'd100, 32'd3, c0);
    repeat (5) @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    checkOutput("mid-op reset busy", {31'd0, busy_o}, 32'd0);
    checkOutput("mid-op reset valid", {31'd0, valid_o}, 32'd0);
    checkOutput("mid-op reset result", result_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (40) @(posedge clk_i);
    #1;
    checkOutput("after reset busy", {31'd0, busy_o}, 32'd0);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL leftover: got %0d outstanding results, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
